// File: rtl/mole_target.sv
// Whack-a-mole target controller: synchronizes and debounces the player's button,
// arms on the game's raise command and reports one hit pulse per raise.
module mole_target #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int HIT_PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       target_up,
    input  logic       btn_raw,
    output logic       hit_n,
    output logic       target_led,
    output logic       btn_db,
    output logic [7:0] false_press
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW_W = (HIT_PULSE_CYCLES > 1) ? $clog2(HIT_PULSE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(HIT_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        HIT       = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    state_t          state, state_next;
    logic            sync_p0, sync_p1;
    logic [DB_W-1:0] db_cnt;
    logic            db_prev;
    logic            btn_rise;
    logic [PW_W-1:0] pcnt, pcnt_next;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizer, then debounce against the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            db_cnt  <= '0;
            btn_db  <= 1'b0;
            db_prev <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            db_prev <= btn_db;
            if (sync_p1 != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= sync_p1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign btn_rise = btn_db & ~db_prev;

    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        unique case (state)
            IDLE: begin
                if (target_up) state_next = ARMED;
            end
            ARMED: begin
                if (!target_up) begin
                    state_next = IDLE;
                end else if (btn_rise) begin
                    state_next = HIT;
                    pcnt_next  = '0;
                end
            end
            HIT: begin
                // The pulse always runs to completion; target_up is ignored here
                if (pcnt == PW_LAST) state_next = WAIT_DROP;
                else                 pcnt_next  = pcnt + 1'b1;
            end
            WAIT_DROP: begin
                if (!target_up) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p2: state and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pcnt        <= '0;
            hit_n       <= 1'b1;
            target_led  <= 1'b0;
            false_press <= 8'd0;
        end else begin
            state      <= state_next;
            pcnt       <= pcnt_next;
            hit_n      <= (state_next != HIT);
            target_led <= (state_next == ARMED);
            if (btn_rise && (state == IDLE || state == WAIT_DROP))
                false_press <= sat_inc8(false_press);
        end
    end

endmodule

// File: tb/tb_mole_target.sv
// Directed bench for mole_target with DEBOUNCE_CYCLES=4, HIT_PULSE_CYCLES=2.
module tb_mole_target;

    logic       clk;
    logic       rst_n;
    logic       target_up;
    logic       btn_raw;
    logic       hit_n;
    logic       target_led;
    logic       btn_db;
    logic [7:0] false_press;

    int n_checks = 0;
    int n_errors = 0;
    logic saw_hit, saw_led, saw_db;

    mole_target #(
        .DEBOUNCE_CYCLES (4),
        .HIT_PULSE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .target_up  (target_up),
        .btn_raw    (btn_raw),
        .hit_n      (hit_n),
        .target_led (target_led),
        .btn_db     (btn_db),
        .false_press(false_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 ns after each and accumulating activity flags
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (hit_n === 1'b0)      saw_hit = 1'b1;
            if (target_led === 1'b1) saw_led = 1'b1;
            if (btn_db === 1'b1)     saw_db  = 1'b1;
        end
    endtask

    task automatic clear_flags();
        saw_hit = 1'b0;
        saw_led = 1'b0;
        saw_db  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        target_up = 1'b0;
        btn_raw   = 1'b0;
        clear_flags();
        tick(2);
        check("rst_hit_n", hit_n, 1);
        check("rst_led", target_led, 0);
        check("rst_btn_db", btn_db, 0);
        check("rst_false_press", false_press, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean hit
        target_up = 1'b1;
        tick(1);
        check("arm_led", target_led, 1);
        btn_raw = 1'b1;
        tick(5);
        check("clean_db_before", btn_db, 0);
        tick(1);
        check("clean_db_rise", btn_db, 1);
        check("clean_hit_n_idle", hit_n, 1);
        check("clean_led_armed", target_led, 1);
        tick(1);
        check("clean_pulse1", hit_n, 0);
        check("clean_led_off", target_led, 0);
        tick(1);
        check("clean_pulse2", hit_n, 0);
        tick(1);
        check("clean_pulse_end", hit_n, 1);
        tick(1);
        btn_raw   = 1'b0;
        target_up = 1'b0;
        tick(8);
        check("clean_db_fall", btn_db, 0);
        check("clean_no_false", false_press, 0);
        check("clean_led_idle", target_led, 0);

        // Glitch shorter than the debounce window while armed
        target_up = 1'b1;
        tick(1);
        clear_flags();
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(10);
        check("glitch_db", saw_db, 0);
        check("glitch_hit", saw_hit, 0);
        check("glitch_false", false_press, 0);
        check("glitch_led", target_led, 1);
        target_up = 1'b0;
        tick(2);

        // Button held before the raise
        btn_raw = 1'b1;
        tick(8);
        check("held_db", btn_db, 1);
        check("held_false", false_press, 1);
        target_up = 1'b1;
        clear_flags();
        tick(10);
        check("held_no_hit", saw_hit, 0);
        check("held_led", target_led, 1);
        target_up = 1'b0;
        btn_raw   = 1'b0;
        tick(8);

        // Target dropped during the pulse
        target_up = 1'b1;
        tick(1);
        btn_raw = 1'b1;
        tick(7);
        check("drop_pulse1", hit_n, 0);
        target_up = 1'b0;
        tick(1);
        check("drop_pulse2", hit_n, 0);
        tick(1);
        check("drop_pulse_end", hit_n, 1);
        btn_raw = 1'b0;
        tick(8);
        target_up = 1'b1;
        tick(1);
        check("drop_rearm", target_led, 1);

        // Second press while target_up stays high
        btn_raw = 1'b1;
        tick(7);
        check("second_first_pulse", hit_n, 0);
        tick(2);
        check("second_pulse_end", hit_n, 1);
        btn_raw = 1'b0;
        tick(8);
        clear_flags();
        btn_raw = 1'b1;
        tick(8);
        check("second_no_hit", saw_hit, 0);
        check("second_false", false_press, 2);
        check("second_led", target_led, 0);
        btn_raw   = 1'b0;
        target_up = 1'b0;
        tick(8);
        target_up = 1'b1;
        tick(1);
        check("second_rearm", target_led, 1);
        target_up = 1'b0;
        tick(2);

        // Saturation of the false-press counter
        clear_flags();
        for (int p = 0; p < 250; p++) begin
            btn_raw = 1'b1;
            tick(7);
            btn_raw = 1'b0;
            tick(7);
        end
        check("sat_mid", false_press, 252);
        for (int p = 0; p < 10; p++) begin
            btn_raw = 1'b1;
            tick(7);
            btn_raw = 1'b0;
            tick(7);
        end
        check("sat_final", false_press, 255);
        check("sat_led", saw_led, 0);
        check("sat_hit", saw_hit, 0);

        // Reset during the first hit_n-low cycle
        target_up = 1'b1;
        tick(1);
        btn_raw = 1'b1;
        tick(7);
        check("rstmid_pulse", hit_n, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_hit_n", hit_n, 1);
        check("rstmid_led", target_led, 0);
        check("rstmid_db", btn_db, 0);
        check("rstmid_false", false_press, 0);
        btn_raw   = 1'b0;
        target_up = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("post_rst_db", btn_db, 0);
        check("post_rst_hit_n", hit_n, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
